// File: rtl/gcd_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gcd_req_scheduler
// Purpose  : Round-robin arbiter feeding one iterative (Euclid, one modulo
//            step per cycle) 8-bit GCD engine shared by four requesters.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_req_scheduler #(
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_mask,
    input  logic [8*NREQ-1:0]     a_flat,
    input  logic [8*NREQ-1:0]     b_flat,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            done_id,
    output logic [7:0]            gcd_out
);

    localparam int c_DW  = 8;
    localparam int c_IDW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [c_IDW-1:0]  r_ptr;
    logic [c_IDW-1:0]  r_owner;
    logic [c_DW-1:0]   r_a;
    logic [c_DW-1:0]   r_b;

    logic [NREQ-1:0]   w_active;
    logic              w_any;
    logic              w_found;
    logic [c_IDW-1:0]  w_idx;
    logic [c_IDW-1:0]  w_win;
    logic [NREQ-1:0]   w_onehot;
    logic [c_DW-1:0]   w_sel_a;
    logic [c_DW-1:0]   w_sel_b;
    logic [c_DW-1:0]   w_max;
    logic [c_DW-1:0]   w_min;
    logic [c_DW-1:0]   w_mod;

    logic [c_DW-1:0]   w_a_arr [NREQ];
    logic [c_DW-1:0]   w_b_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_a_arr[gi] = a_flat[gi*c_DW +: c_DW];
            assign w_b_arr[gi] = b_flat[gi*c_DW +: c_DW];
        end
    endgenerate

    assign w_active = req & req_mask;
    assign w_any    = |w_active;

    // Rotating priority: first active index at or above the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = r_ptr + k[c_IDW-1:0];
            if (!w_found && w_active[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_sel_a  = w_a_arr[w_win];
    assign w_sel_b  = w_b_arr[w_win];
    assign w_max    = (w_sel_a >= w_sel_b) ? w_sel_a : w_sel_b;
    assign w_min    = (w_sel_a >= w_sel_b) ? w_sel_b : w_sel_a;
    // Guarded so the divider never sees a zero divisor.
    assign w_mod    = (r_b != '0) ? (r_a % r_b) : '0;

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:    w_next_state = w_any ? CALC : IDLE;
            CALC:    w_next_state = (r_b == '0) ? DONE : CALC;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_a     <= '0;
            r_b     <= '0;
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            gcd_out <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= w_max;
                        r_b     <= w_min;
                        r_owner <= w_win;
                        r_ptr   <= w_win + 1'b1;
                        gnt     <= w_onehot;
                    end
                end
                CALC: begin
                    if (r_b != '0) begin
                        r_a <= r_b;
                        r_b <= w_mod;
                    end else begin
                        gcd_out <= r_a;
                        done_id <= r_owner;
                        done    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_req_scheduler
// Purpose  : Directed, self-checking bench for gcd_req_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_req_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req_mask;
    logic [31:0] a_flat;
    logic [31:0] b_flat;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [7:0]  gcd_out;

    int checks = 0;
    int errors = 0;

    gcd_req_scheduler #(.NREQ(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_mask (req_mask),
        .a_flat   (a_flat),
        .b_flat   (b_flat),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .gcd_out  (gcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        a_flat[8*i +: 8] = a;
        b_flat[8*i +: 8] = b;
    endtask

    // Entered at a falling edge of an IDLE cycle with req already set up.
    task automatic txn(input string tag, input logic [3:0] eg, input int elat,
                       input logic [7:0] eq, input logic [1:0] eid,
                       input bit drop, input bit corrupt);
        int n;
        @(negedge clk);
        check({tag, "_gnt"}, gnt, eg);
        check({tag, "_busy"}, busy, 1);
        if (drop)    req = req & ~eg;
        if (corrupt) begin
            a_flat = ~a_flat;
            b_flat = ~b_flat;
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, elat);
        check({tag, "_gcd"}, gcd_out, eq);
        check({tag, "_id"}, done_id, eid);
        check({tag, "_gnt0"}, gnt, 0);
        @(negedge clk);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_done0"}, done, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_mask = 4'b1111;
        a_flat   = '0;
        b_flat   = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_id", done_id, 0);
        check("rst_gcd", gcd_out, 0);

        // Single request, accepted on the first edge after reset release.
        set_ops(0, 8'd48, 8'd18);
        req   = 4'b0001;
        rst_n = 1'b1;
        txn("single", 4'b0001, 4, 8'd6, 2'd0, 1, 0);

        // No active request: IDLE holds, results stay put.
        repeat (3) @(negedge clk);
        check("noreq_busy", busy, 0);
        check("noreq_gnt", gnt, 0);
        check("noreq_gcd", gcd_out, 6);

        set_ops(1, 8'd5, 8'd5);
        req = 4'b0010;
        txn("eq55", 4'b0010, 2, 8'd5, 2'd1, 1, 0);
        set_ops(2, 8'd9, 8'd0);
        req = 4'b0100;
        txn("b0", 4'b0100, 1, 8'd9, 2'd2, 1, 0);
        set_ops(3, 8'd0, 8'd0);
        req = 4'b1000;
        txn("zero", 4'b1000, 1, 8'd0, 2'd3, 1, 0);
        set_ops(0, 8'd1, 8'd255);
        req = 4'b0001;
        txn("swap", 4'b0001, 2, 8'd1, 2'd0, 1, 0);

        // Pointer now 1: requester 3 beats requester 0.
        set_ops(3, 8'd12, 8'd8);
        req = 4'b1001;
        txn("rr3", 4'b1000, 3, 8'd4, 2'd3, 1, 0);
        txn("rr0", 4'b0001, 2, 8'd1, 2'd0, 1, 0);

        // Fresh reset so fairness starts from pointer 0.
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_gcd", gcd_out, 0);
        for (int i = 0; i < 4; i++) set_ops(i, 8'd12, 8'd8);
        req   = 4'b1111;
        rst_n = 1'b1;
        txn("fair0", 4'b0001, 3, 8'd4, 2'd0, 0, 0);
        txn("fair1", 4'b0010, 3, 8'd4, 2'd1, 0, 0);
        txn("fair2", 4'b0100, 3, 8'd4, 2'd2, 0, 0);
        txn("fair3", 4'b1000, 3, 8'd4, 2'd3, 0, 0);
        txn("fair4", 4'b0001, 3, 8'd4, 2'd0, 0, 0);

        // Mask: requester 3 stays blocked even when the pointer reaches it.
        req      = 4'b1010;
        req_mask = 4'b0010;
        txn("mask1a", 4'b0010, 3, 8'd4, 2'd1, 0, 0);
        txn("mask1b", 4'b0010, 3, 8'd4, 2'd1, 0, 0);
        req = 4'b1000;
        repeat (3) @(negedge clk);
        check("mask3_busy", busy, 0);
        check("mask3_gnt", gnt, 0);
        req      = 4'b0000;
        req_mask = 4'b1111;

        // Operands altered after grant must not affect the result.
        set_ops(0, 8'd48, 8'd18);
        req = 4'b0001;
        txn("latch", 4'b0001, 4, 8'd6, 2'd0, 1, 1);

        // Reset in the middle of a computation.
        a_flat = '0;
        b_flat = '0;
        set_ops(0, 8'd255, 8'd254);
        req = 4'b0001;
        @(negedge clk);
        check("mid_gnt", gnt, 4'b0001);
        req = 4'b0000;
        @(negedge clk);
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_gcd", gcd_out, 0);
        check("mid_rst_id", done_id, 0);
        check("mid_rst_gnt", gnt, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_done", done, 0);
        end
        set_ops(2, 8'd20, 8'd15);
        req   = 4'b0100;
        rst_n = 1'b1;
        txn("post_rst", 4'b0100, 3, 8'd5, 2'd2, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gcd_req_scheduler.md
GCD_REQ_SCHEDULER -- requirements
Module: gcd_req_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (fixed at 4 in this revision).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req  input  4  per-requester request, level, held until matching gnt bit seen.
REQ-005 SHALL have port req_mask  input  4  enable mask; req[i] ignored when req_mask[i]=0.
REQ-006 SHALL have port a_flat  input  32  operand A of requester i at bits [8i+7:8i], unsigned.
REQ-007 SHALL have port b_flat  input  32  operand B of requester i at bits [8i+7:8i], unsigned.
REQ-008 SHALL have port gnt  output  4  one-hot grant pulse, registered.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port done_id  output  2  index of requester owning the current result.
REQ-012 SHALL have port gcd_out  output  8  GCD result, registered, held until next completion.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; unused encodings SHALL return to IDLE.
REQ-014 SHALL sample req & req_mask only in IDLE; requests arriving in CALC/DONE wait, none lost while held.
REQ-015 SHALL arbitrate round-robin: search from pointer ptr upward modulo 4, first active index i wins.
REQ-016 SHALL, on acceptance edge in IDLE: latch a_reg=max(A_i,B_i), b_reg=min(A_i,B_i), owner=i, ptr=(i+1) mod 4, go CALC.
REQ-017 SHALL assert gnt[i] for exactly the first CALC cycle after acceptance; gnt=0 otherwise.
REQ-018 SHALL, each CALC cycle with b_reg!=0, perform a_reg<=b_reg, b_reg<=a_reg % b_reg (one modulo step per cycle).
REQ-019 SHALL, in CALC with b_reg==0, load gcd_out<=a_reg, done_id<=owner, go DONE.
REQ-020 SHALL assert done for the single DONE cycle, then return to IDLE; next acceptance possible in that IDLE cycle.
REQ-021 SHALL give latency: done high exactly N+1 cycles after the gnt cycle, N = number of nonzero-b modulo steps.
REQ-022 SHALL define gcd(x,0)=x and gcd(0,0)=0; no error output.
REQ-023 SHALL not begin a new acceptance when all req & req_mask bits are zero; IDLE holds, ptr unchanged.
REQ-024 SHALL keep gcd_out and done_id stable outside the completion edge.
REQ-025 SHALL ignore operand and req changes during CALC/DONE (operands latched at acceptance only).
REQ-026 SHALL keep busy combinational from state: busy=1 in CALC and DONE.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-CALC, asynchronously force state=IDLE, ptr=0, a_reg=b_reg=0, owner=0, gnt=0, done=0, done_id=0, gcd_out=0.
REQ-028 SHALL discard any in-flight computation on reset; no done pulse produced for it.
REQ-029 SHALL accept a request on the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL cover single request: req=0001, A0=48, B0=18 -> gnt=0001 one cycle, done 4 cycles later, gcd_out=6, done_id=0.
REQ-031 SHALL cover boundaries: (5,5)->done 2 cycles after gnt, gcd 5; (9,0)->done 1 cycle after gnt, gcd 9; (0,0)->gcd 0; (255,1)->gcd 1.
REQ-032 SHALL cover fairness: req=1111 held continuously, operands (12,8) each -> grants in order 0,1,2,3,0, each result 4 with matching done_id.
REQ-033 SHALL cover mask: req=1010, req_mask=0010 -> only requester 1 granted; requester 3 never granted while masked.
REQ-034 SHALL cover reset mid-CALC: assert rst_n=0 during (255,254) computation -> all outputs 0 immediately, no done; next req=0100 granted to requester 2 first cycle after reset.
REQ-035 SHALL cover operand change during CALC: alter a_flat/b_flat after gnt -> result reflects latched operands only.
